pipeline_ctrl: RTL and testbench

Central hazard and stall controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It drives the write-enable and clear of the PC and the four stage registers. It resolves four hazards: data-memory wait states, taken branches/jumps resolved in MEM, load-use hazards between EX and ID, and instruction-memory wait states. A sticky error/halt state is entered on data-memory timeout.

---
 rtl/pipeline_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Function : Hazard and stall controller for the 5-stage pipeline
//            (IF/ID/EX/MEM/WB). Drives PC/stage-register advance enables and
//            bubble clears, resolving data-memory stalls, MEM-stage redirects,
//            load-use hazards and instruction-memory waits. Enters a sticky
//            halt when a data-memory access exceeds DMEM_TIMEOUT wait cycles.
//            Optional macro HAZ_PERF_EN builds the stall/flush counters;
//            without it both counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        em_take_branch,
    input  logic        de_mem_read,
    input  logic [4:0]  de_dst_reg,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_uses_rt,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        de_wren,
    output logic        em_wren,
    output logic        mw_wren,
    output logic        fd_clr,
    output logic        de_clr,
    output logic        em_clr,
    output logic        mw_clr,
    output logic        pc_sel,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DWAIT = 2'd1;
    localparam logic [1:0] c_ST_ERR   = 2'd2;
    localparam logic [7:0] c_WCNT_MAX = 8'(DMEM_TIMEOUT);

    logic [1:0] r_state;
    logic [7:0] r_wcnt;
    logic       r_rst_q;

    logic w_blank;
    logic w_p1;
    logic w_p2;
    logic w_p3;
    logic w_p4;
    logic w_flush_evt;

    // Outputs stay in the reset pattern for reset and the cycle right after it
    assign w_blank = reset | r_rst_q;

    // Hazard conditions, listed highest priority first
    assign w_p1 = dmem_req & ~dmem_ack;
    assign w_p2 = em_take_branch;
    assign w_p3 = de_mem_read & (de_dst_reg != 5'd0) &
                  ((de_dst_reg == fd_rs) | (fd_uses_rt & (de_dst_reg == fd_rt)));
    assign w_p4 = ~imem_ready;

    // A redirect is actually applied only outside blanking/ERR and without a dmem stall
    assign w_flush_evt = ~w_blank & (r_state != c_ST_ERR) & ~w_p1 & w_p2;

    // Delayed copy of reset that extends the blanking window by one cycle
    always_ff @(posedge clk) begin
        r_rst_q <= reset;
    end

    // Controller state machine: RUN / DWAIT with wait counter / sticky ERR
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RUN;
            r_wcnt  <= 8'd0;
        end else if (r_rst_q) begin
            r_state <= c_ST_RUN;
            r_wcnt  <= 8'd0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_p1) begin
                        r_state <= c_ST_DWAIT;
                        r_wcnt  <= 8'd1;
                    end
                end
                c_ST_DWAIT: begin
                    if (w_p1) begin
                        if (r_wcnt == c_WCNT_MAX) begin
                            r_state <= c_ST_ERR;
                        end else begin
                            r_wcnt <= r_wcnt + 8'd1;
                        end
                    end else begin
                        // Ack cycle: back to RUN, this cycle already decoded as RUN
                        r_state <= c_ST_RUN;
                        r_wcnt  <= 8'd0;
                    end
                end
                c_ST_ERR: begin
                    r_state <= c_ST_ERR;
                end
                default: begin
                    r_state <= c_ST_RUN;
                    r_wcnt  <= 8'd0;
                end
            endcase
        end
    end

    // Enable/clear decode from state and current hazard inputs
    always_comb begin
        pc_wren = 1'b1;
        fd_wren = 1'b1;
        de_wren = 1'b1;
        em_wren = 1'b1;
        mw_wren = 1'b1;
        fd_clr  = 1'b0;
        de_clr  = 1'b0;
        em_clr  = 1'b0;
        mw_clr  = 1'b0;
        pc_sel  = 1'b0;
        halted  = 1'b0;
        if (w_blank) begin
            pc_wren = 1'b0;
            fd_wren = 1'b0;
            de_wren = 1'b0;
            em_wren = 1'b0;
            mw_wren = 1'b0;
            fd_clr  = 1'b1;
            de_clr  = 1'b1;
            em_clr  = 1'b1;
            mw_clr  = 1'b1;
        end else if (r_state == c_ST_ERR) begin
            pc_wren = 1'b0;
            fd_wren = 1'b0;
            de_wren = 1'b0;
            em_wren = 1'b0;
            mw_wren = 1'b0;
            halted  = 1'b1;
        end else if (w_p1) begin
            // Freeze everything upstream of MEM, push a bubble into WB
            pc_wren = 1'b0;
            fd_wren = 1'b0;
            de_wren = 1'b0;
            em_wren = 1'b0;
            mw_clr  = 1'b1;
        end else if (w_p2) begin
            // Redirect and squash the three younger instructions
            pc_sel = 1'b1;
            fd_clr = 1'b1;
            de_clr = 1'b1;
            em_clr = 1'b1;
        end else begin
            if (w_p3) begin
                pc_wren = 1'b0;
                fd_wren = 1'b0;
                de_clr  = 1'b1;
            end
            if (w_p4) begin
                pc_wren = 1'b0;
                // A held FD register must keep its instruction, so no clear then
                if (!w_p3) begin
                    fd_clr = 1'b1;
                end
            end
        end
    end

`ifdef HAZ_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Saturating performance counters for stalled cycles and branch flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!r_rst_q && !pc_wren && (r_state != c_ST_ERR) &&
                (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush_evt && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    logic w_unused_flush;
    assign w_unused_flush = w_flush_evt;
    assign stall_cycles   = 32'd0;
    assign flush_count    = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Function : Directed self-checking bench for pipeline_ctrl. One instance uses
//            the default timeout, a second one uses DMEM_TIMEOUT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    // Output bundle order: pc fd de em mw wren | fd de em mw clr | pc_sel | halted
    localparam logic [10:0] c_RST  = 11'b11111_1111_0_0 & 11'b00000_1111_1_1 & 11'b00000_1111_0_0;
    localparam logic [10:0] c_RUN  = 11'b11111_0000_0_0;
    localparam logic [10:0] c_LU   = 11'b00111_0100_0_0;
    localparam logic [10:0] c_DST  = 11'b00001_0001_0_0;
    localparam logic [10:0] c_BR   = 11'b11111_1110_1_0;
    localparam logic [10:0] c_IW   = 11'b01111_1000_0_0;
    localparam logic [10:0] c_ERR  = 11'b00000_0000_0_1;

`ifdef HAZ_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ack;
    logic        em_take_branch;
    logic        de_mem_read;
    logic [4:0]  de_dst_reg;
    logic [4:0]  fd_rs;
    logic [4:0]  fd_rt;
    logic        fd_uses_rt;

    logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
    logic        fd_clr, de_clr, em_clr, mw_clr, pc_sel, halted;
    logic [31:0] stall_cycles, flush_count;

    logic        t_pc_wren, t_fd_wren, t_de_wren, t_em_wren, t_mw_wren;
    logic        t_fd_clr, t_de_clr, t_em_clr, t_mw_clr, t_pc_sel, t_halted;
    logic [31:0] t_stall_cycles, t_flush_count;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_ctrl u_dut (
        .clk            (clk),
        .reset          (reset),
        .imem_ready     (imem_ready),
        .dmem_req       (dmem_req),
        .dmem_ack       (dmem_ack),
        .em_take_branch (em_take_branch),
        .de_mem_read    (de_mem_read),
        .de_dst_reg     (de_dst_reg),
        .fd_rs          (fd_rs),
        .fd_rt          (fd_rt),
        .fd_uses_rt     (fd_uses_rt),
        .pc_wren        (pc_wren),
        .fd_wren        (fd_wren),
        .de_wren        (de_wren),
        .em_wren        (em_wren),
        .mw_wren        (mw_wren),
        .fd_clr         (fd_clr),
        .de_clr         (de_clr),
        .em_clr         (em_clr),
        .mw_clr         (mw_clr),
        .pc_sel         (pc_sel),
        .halted         (halted),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    pipeline_ctrl #(.DMEM_TIMEOUT(3)) u_dut_to (
        .clk            (clk),
        .reset          (reset),
        .imem_ready     (imem_ready),
        .dmem_req       (dmem_req),
        .dmem_ack       (dmem_ack),
        .em_take_branch (em_take_branch),
        .de_mem_read    (de_mem_read),
        .de_dst_reg     (de_dst_reg),
        .fd_rs          (fd_rs),
        .fd_rt          (fd_rt),
        .fd_uses_rt     (fd_uses_rt),
        .pc_wren        (t_pc_wren),
        .fd_wren        (t_fd_wren),
        .de_wren        (t_de_wren),
        .em_wren        (t_em_wren),
        .mw_wren        (t_mw_wren),
        .fd_clr         (t_fd_clr),
        .de_clr         (t_de_clr),
        .em_clr         (t_em_clr),
        .mw_clr         (t_mw_clr),
        .pc_sel         (t_pc_sel),
        .halted         (t_halted),
        .stall_cycles   (t_stall_cycles),
        .flush_count    (t_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] bundle();
        return {pc_wren, fd_wren, de_wren, em_wren, mw_wren,
                fd_clr, de_clr, em_clr, mw_clr, pc_sel, halted};
    endfunction

    function automatic logic [10:0] bundle_to();
        return {t_pc_wren, t_fd_wren, t_de_wren, t_em_wren, t_mw_wren,
                t_fd_clr, t_de_clr, t_em_clr, t_mw_clr, t_pc_sel, t_halted};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready     = 1'b1;
        dmem_req       = 1'b0;
        dmem_ack       = 1'b0;
        em_take_branch = 1'b0;
        de_mem_read    = 1'b0;
        de_dst_reg     = 5'd0;
        fd_rs          = 5'd0;
        fd_rt          = 5'd0;
        fd_uses_rt     = 1'b0;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        check_val("rst_hold0", {21'd0, bundle()}, {21'd0, c_RST});
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_hold", {21'd0, bundle()}, {21'd0, c_RST});
        end
        reset = 1'b0;
        #1;
        check_val("rst_post", {21'd0, bundle()}, {21'd0, c_RST});
        check_val("rst_stall_cnt", stall_cycles, 32'd0);
        check_val("rst_flush_cnt", flush_count, 32'd0);
        tick();
        check_val("run_idle", {21'd0, bundle()}, {21'd0, c_RUN});

        // Load-use on rs
        de_mem_read = 1'b1; de_dst_reg = 5'd5; fd_rs = 5'd5;
        #1;
        check_val("lu_rs", {21'd0, bundle()}, {21'd0, c_LU});
        tick();
        de_mem_read = 1'b0;
        #1;
        check_val("lu_after", {21'd0, bundle()}, {21'd0, c_RUN});
        // r0 destination never hazards
        de_mem_read = 1'b1; de_dst_reg = 5'd0; fd_rs = 5'd0;
        #1;
        check_val("lu_r0", {21'd0, bundle()}, {21'd0, c_RUN});
        // rt match only counts when rt is read
        de_dst_reg = 5'd7; fd_rs = 5'd3; fd_rt = 5'd7; fd_uses_rt = 1'b0;
        #1;
        check_val("lu_rt_unused", {21'd0, bundle()}, {21'd0, c_RUN});
        fd_uses_rt = 1'b1;
        #1;
        check_val("lu_rt", {21'd0, bundle()}, {21'd0, c_LU});
        // Load-use together with imem wait: FD held, not cleared
        imem_ready = 1'b0;
        #1;
        check_val("lu_imem", {21'd0, bundle()}, {21'd0, c_LU});
        de_mem_read = 1'b0;
        #1;
        check_val("imem_wait", {21'd0, bundle()}, {21'd0, c_IW});
        tick();

        // Dmem stall of 4 cycles, then ack
        reset_pulse();
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("dstall", {21'd0, bundle()}, {21'd0, c_DST});
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        check_val("dack", {21'd0, bundle()}, {21'd0, c_RUN});
        tick();
        dmem_req = 1'b0; dmem_ack = 1'b0;
        #1;
        check_val("dstall_cnt", stall_cycles, c_PERF ? 32'd4 : 32'd0);
        check_val("after_dack", {21'd0, bundle()}, {21'd0, c_RUN});

        // Branch in MEM during a 2-cycle dmem stall: honoured on ack cycle only
        dmem_req = 1'b1; em_take_branch = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_val("br_stall", {21'd0, bundle()}, {21'd0, c_DST});
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        check_val("br_ack", {21'd0, bundle()}, {21'd0, c_BR});
        tick();
        idle_inputs();
        #1;
        check_val("br_flush_cnt", flush_count, c_PERF ? 32'd1 : 32'd0);
        check_val("br_stall_cnt", stall_cycles, c_PERF ? 32'd6 : 32'd0);

        // Ack without request ignored; zero-wait access causes no stall
        dmem_ack = 1'b1;
        #1;
        check_val("ack_noreq", {21'd0, bundle()}, {21'd0, c_RUN});
        dmem_req = 1'b1;
        #1;
        check_val("zero_wait", {21'd0, bundle()}, {21'd0, c_RUN});
        tick();
        dmem_req = 1'b0; dmem_ack = 1'b0;
        #1;
        check_val("zero_wait_nxt", {21'd0, bundle()}, {21'd0, c_RUN});

        // Branch + load-use + imem wait together: branch only
        em_take_branch = 1'b1; imem_ready = 1'b0;
        de_mem_read = 1'b1; de_dst_reg = 5'd9; fd_rs = 5'd9;
        #1;
        check_val("br_priority", {21'd0, bundle()}, {21'd0, c_BR});
        tick();
        idle_inputs();
        #1;
        check_val("br2_flush_cnt", flush_count, c_PERF ? 32'd2 : 32'd0);

        // Timeout instance: 3 counted wait cycles, then sticky ERR
        reset_pulse();
        dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("to_stall", {21'd0, bundle_to()}, {21'd0, c_DST});
            tick();
        end
        check_val("to_err", {21'd0, bundle_to()}, {21'd0, c_ERR});
        check_val("long_stall", {21'd0, bundle()}, {21'd0, c_DST});
        dmem_req = 1'b0;
        tick();
        check_val("to_sticky", {21'd0, bundle_to()}, {21'd0, c_ERR});
        dmem_ack = 1'b1; dmem_req = 1'b1;
        #1;
        check_val("to_sticky_ack", {21'd0, bundle_to()}, {21'd0, c_ERR});
        idle_inputs();
        reset = 1'b1;
        #1;
        check_val("to_rst", {21'd0, bundle_to()}, {21'd0, c_RST});
        tick();
        reset = 1'b0;
        #1;
        check_val("to_rst_post", {21'd0, bundle_to()}, {21'd0, c_RST});
        tick();
        check_val("to_run", {21'd0, bundle_to()}, {21'd0, c_RUN});
        check_val("to_run_cnt", stall_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
